jtag_uart_echo: RTL and testbench
=================================

Name: jtag_uart_echo

Overview:
- Parametrised Avalon-MM master that services the JTAG UART slave's 8-bit-data/32-bit-bus port (1-bit address, active-low read/write strobes, waitrequest).
- Polls the UART and buffers received characters in an internal FIFO. Returns them to the host unchanged, upper-cased, or replaces host traffic with a generated counting pattern.
- Sits beside jtag_uart in the FPGA top level and replaces the tied-off chipselect. Gives board bring-up a self-contained console loopback.

Parameters:
- DEPTH, 16, internal character FIFO depth; power of two, 2..256.
- POLL_CYCLES, 1024, idle cycles between poll rounds; minimum 1.
- TIMEOUT, 4095, maximum cycles a single bus command may stall on waitrequest.
- CNT_W, 16, width of the rx/tx character counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when 0, no new poll round starts; an in-flight command completes.
- mode  input  2  0 echo, 1 echo upper-case, 2 counting pattern, 3 receive-only (drain, no transmit).
- av_address  output  1  0 = data register, 1 = control register.
- av_read_n  output  1  active-low read strobe.
- av_write_n  output  1  active-low write strobe.
- av_writedata  output  32  write data; bits [31:8] are always 0.
- av_readdata  input  32  read data.
- av_waitrequest  input  1  slave stall.
- rx_count  output  CNT_W  characters accepted into the FIFO; saturating.
- tx_count  output  CNT_W  characters written to the UART; saturating.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- timeout_err  output  1  sticky; set when a command exceeds TIMEOUT.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values: av_read_n=1, av_write_n=1, av_address=0, av_writedata=0, rx_count=0, tx_count=0, fifo_level=0, timeout_err=0. FIFO is emptied, pattern byte=0x00, poll timer=POLL_CYCLES, state=IDLE.
- Reset asserted mid-command drops the strobes on the next edge. No partial state survives.
- Bus rules:
  - A command holds address, strobe and writedata constant while av_waitrequest=1.
  - The command completes on the first edge with av_waitrequest=0; readdata is sampled on that edge.
  - At most one strobe is low at any time.
  - Strobes return high for at least one cycle between commands.
- FSM states: IDLE, RD_DATA, RD_CTRL, WR_DATA, GAP.
  - IDLE: the poll timer counts down to 0, then reloads.
    - If enable=1 and mode in {0,1,3} and the FIFO is not full, go to RD_DATA.
    - Else if enable=1 and mode in {0,1,2}, go to RD_CTRL.
    - Otherwise stay in IDLE.
  - RD_DATA: read from address 0. On completion:
    - If RVALID (bit 15) = 1, push readdata[7:0] and increment rx_count.
    - If RAVAIL (bits [31:16]) > 0 and the FIFO is not full after the push, issue RD_DATA again (via GAP).
    - Otherwise go to RD_CTRL, or to IDLE if mode=3.
  - RD_CTRL: read from address 1 and latch WSPACE = readdata[31:16].
    - Go to WR_DATA if WSPACE>0 and there is a source character: FIFO not empty (modes 0/1), or always in mode 2.
    - Otherwise go to IDLE.
  - WR_DATA: write the character to address 0.
    - Mode 0: FIFO head unchanged. Mode 1: bytes 0x61..0x7A become 0x41..0x5A; all other bytes unchanged. Mode 2: the pattern byte.
    - On completion: pop the FIFO (modes 0/1) or increment the pattern byte mod 256 (mode 2); increment tx_count; decrement the local WSPACE copy.
    - Repeat WR_DATA (via GAP) while local WSPACE>0 and a source character remains. Otherwise go to IDLE.
  - GAP: one cycle with both strobes high.
- mode is sampled only on the IDLE exit. A change mid-round takes effect in the next round.
- Timeout: a per-command stall counter increments while waitrequest=1.
  - Upon reaching TIMEOUT, the strobe is deasserted, timeout_err is set, and the FSM goes to IDLE.
  - An aborted read pushes nothing; an aborted write pops nothing.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- The FIFO is never overrun. RD_DATA is not issued when the FIFO is full, so no character is ever dropped.

Test Plan:
- Echo: mode=0; slave presents 3 characters 'a','b','c' (RAVAIL 2,1,0) with WSPACE=64 → 3 data reads, then writes 0x61,0x62,0x63 in order; rx_count=3, tx_count=3, fifo_level returns to 0.
- Upper-case: mode=1; input "aZ{" → writes 0x41,0x5A,0x7B.
- Backpressure: DEPTH=4; slave offers 10 characters with WSPACE=0 → exactly 4 reads accepted, fifo_level=4, no further data reads. Then WSPACE=2 → 2 writes; the next round reads 2 more characters.
- Pattern: mode=2, WSPACE=300 across rounds → bytes 0x00..0xFF then 0x00..0x2B; tx_count=300; zero data reads issued.
- Waitrequest: hold waitrequest=1 for 5 cycles on each command → address, strobe and writedata stable throughout; completion on the first low cycle. Hold waitrequest for TIMEOUT cycles → strobe released, timeout_err=1, FIFO unchanged.
- Reset mid-write: assert reset while av_write_n=0 with waitrequest=1 → next edge: av_write_n=1, all counters 0, fifo_level=0, timeout_err=0.

Source files
------------

// File: rtl/jtag_uart_echo.sv
// jtag_uart_echo: Avalon-MM master for the JTAG UART slave port.
//   Polls the UART data register, buffers received characters in a local
//   FIFO and writes them back unchanged, upper-cased, or replaced by a
//   counting pattern. Mode 3 only drains the UART and transmits nothing.
//
// Bus handshake: a command is the cycle range where exactly one strobe is
// low. Address, strobe and writedata stay constant while av_waitrequest=1.
// The command completes on the first edge where av_waitrequest=0, and
// readdata is sampled on that edge. Strobes always go high for at least one
// cycle (GAP or IDLE) before the next command.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            allows new poll rounds to start
//   mode[1:0]         0 echo, 1 upper-case echo, 2 pattern, 3 receive-only
//   av_*              Avalon-MM master towards jtag_uart
//   rx_count/tx_count saturating character counters
//   fifo_level        FIFO occupancy
//   timeout_err       sticky, a command stalled for TIMEOUT cycles
//   state_dbg         current FSM state (debug)
module jtag_uart_echo #(
    parameter int DEPTH       = 16,
    parameter int POLL_CYCLES = 1024,
    parameter int TIMEOUT     = 4095,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               mode,
    output logic                     av_address,
    output logic                     av_read_n,
    output logic                     av_write_n,
    output logic [31:0]              av_writedata,
    input  logic [31:0]              av_readdata,
    input  logic                     av_waitrequest,
    output logic [CNT_W-1:0]         rx_count,
    output logic [CNT_W-1:0]         tx_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     timeout_err,
    output logic [2:0]               state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_DATA = 3'd1,
        S_RD_CTRL = 3'd2,
        S_WR_DATA = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t           r_state, w_next;
    state_t           r_after, w_after_next;  // command to issue after GAP
    logic [1:0]       r_mode;
    logic [PW-1:0]    r_poll;
    logic [TW-1:0]    r_stall;
    logic [15:0]      r_wspace;
    logic [7:0]       r_pattern;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_rx_count, r_tx_count;
    logic             r_timeout_err;

    logic             w_cmd, w_done, w_abort, w_full, w_push, w_pop;
    logic             w_full_after, w_src_after;
    logic [7:0]       w_head, w_char;
    logic [AW:0]      w_lvl_after;
    logic             w_unused_rd_bits;

    assign w_unused_rd_bits = &{1'b0, av_readdata[14:8]};

    assign w_cmd   = (r_state == S_RD_DATA) || (r_state == S_RD_CTRL) || (r_state == S_WR_DATA);
    assign w_done  = w_cmd && !av_waitrequest;
    // Abort on the edge where the stall count would reach TIMEOUT.
    assign w_abort = w_cmd && av_waitrequest && (r_stall == TW'(TIMEOUT - 1));
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_push  = (r_state == S_RD_DATA) && w_done && av_readdata[15];
    assign w_pop   = (r_state == S_WR_DATA) && w_done && (r_mode != 2'd2);

    assign w_lvl_after  = w_push ? r_level + (AW+1)'(1) : r_level;
    assign w_full_after = (w_lvl_after == (AW+1)'(DEPTH));
    // After a write completes, is there still something to send?
    assign w_src_after  = (r_mode == 2'd2) || (r_level > (AW+1)'(1));

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_char = w_head;
        if (r_mode == 2'd2) begin
            w_char = r_pattern;
        end else if (r_mode == 2'd1 && w_head >= 8'h61 && w_head <= 8'h7A) begin
            w_char = w_head - 8'h20;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_after_next = r_after;
        av_read_n    = 1'b1;
        av_write_n   = 1'b1;
        av_address   = 1'b0;
        av_writedata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (r_poll == '0) begin
                    if (enable && mode != 2'd2 && !w_full) begin
                        w_next = S_RD_DATA;
                    end else if (enable && mode != 2'd3) begin
                        w_next = S_RD_CTRL;
                    end
                end
            end
            S_RD_DATA: begin
                av_read_n = 1'b0;
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_done) begin
                    if (av_readdata[31:16] != 16'h0 && !w_full_after) begin
                        w_next       = S_GAP;
                        w_after_next = S_RD_DATA;
                    end else if (r_mode == 2'd3) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next       = S_GAP;
                        w_after_next = S_RD_CTRL;
                    end
                end
            end
            S_RD_CTRL: begin
                av_read_n  = 1'b0;
                av_address = 1'b1;
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_done) begin
                    if (av_readdata[31:16] != 16'h0 && (r_mode == 2'd2 || r_level != '0)) begin
                        w_next       = S_GAP;
                        w_after_next = S_WR_DATA;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_WR_DATA: begin
                av_write_n   = 1'b0;
                av_writedata = {24'h0, w_char};
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_done) begin
                    if (r_wspace != 16'd1 && w_src_after) begin
                        w_next       = S_GAP;
                        w_after_next = S_WR_DATA;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                w_next = r_after;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_after       <= S_IDLE;
            r_mode        <= 2'd0;
            r_poll        <= PW'(POLL_CYCLES);
            r_stall       <= '0;
            r_wspace      <= 16'h0;
            r_pattern     <= 8'h0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_rx_count    <= '0;
            r_tx_count    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_after <= w_after_next;

            if (r_state == S_IDLE) begin
                if (r_poll == '0) begin
                    r_poll <= PW'(POLL_CYCLES);
                    r_mode <= mode;
                end else begin
                    r_poll <= r_poll - PW'(1);
                end
            end

            if (w_cmd && av_waitrequest && !w_abort) begin
                r_stall <= r_stall + TW'(1);
            end else begin
                r_stall <= '0;
            end

            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_level  <= r_level + (AW+1)'(1);
                if (r_rx_count != {CNT_W{1'b1}}) begin
                    r_rx_count <= r_rx_count + CNT_W'(1);
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_level  <= r_level - (AW+1)'(1);
            end

            if (r_state == S_RD_CTRL && w_done) begin
                r_wspace <= av_readdata[31:16];
            end

            if (r_state == S_WR_DATA && w_done) begin
                r_wspace <= r_wspace - 16'd1;
                if (r_mode == 2'd2) begin
                    r_pattern <= r_pattern + 8'd1;
                end
                if (r_tx_count != {CNT_W{1'b1}}) begin
                    r_tx_count <= r_tx_count + CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= av_readdata[7:0];
        end
    end

    assign rx_count    = r_rx_count;
    assign tx_count    = r_tx_count;
    assign fifo_level  = r_level;
    assign timeout_err = r_timeout_err;
    assign state_dbg   = r_state;
endmodule

// File: tb/tb_jtag_uart_echo.sv
module tb_jtag_uart_echo;
  localparam int TO = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        enable;
  logic [1:0]  mode;
  logic        av_address, av_read_n, av_write_n;
  logic [31:0] av_writedata, av_readdata;
  logic        av_waitrequest;
  logic [15:0] rx_count, tx_count;
  logic [2:0]  fifo_level;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  jtag_uart_echo #(.DEPTH(4), .POLL_CYCLES(4), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .av_address(av_address), .av_read_n(av_read_n), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest),
    .rx_count(rx_count), .tx_count(tx_count), .fifo_level(fifo_level),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;

  // ---------------- slave model ----------------
  logic [7:0] s_rx_mem [0:63];
  int s_rx_tail = 0;
  int s_rx_head = 0;
  int s_wspace_lim = 0;
  int s_wait_n = 0;
  logic s_hold_all = 1'b0;
  logic s_hold_wr = 1'b0;
  int s_wait_cnt = 0;
  int s_ws;

  int n_wr = 0, n_data_rd = 0, n_ctrl_rd = 0, n_cmd = 0;
  logic [7:0] wr_log [0:511];
  int stall_log [0:1023];
  int viol_both = 0, viol_gap = 0, viol_stable = 0, viol_hi = 0;
  logic prev_wait = 1'b0, prev_done = 1'b0;
  logic [34:0] prev_sig = '0;
  logic s_cmd;
  logic [34:0] s_sig;

  assign s_cmd = !av_read_n || !av_write_n;
  assign s_sig = {av_address, av_read_n, av_write_n, av_writedata};
  assign av_waitrequest = s_cmd && ((s_wait_cnt < s_wait_n) || s_hold_all || (s_hold_wr && !av_write_n));

  always_comb begin
    s_ws = (s_wspace_lim > n_wr) ? s_wspace_lim - n_wr : 0;
    av_readdata = 32'h0;
    if (av_address) av_readdata = {s_ws[15:0], 16'h0};
    else if (s_rx_tail > s_rx_head) av_readdata = {16'(s_rx_tail - s_rx_head - 1), 8'h80, s_rx_mem[s_rx_head]};
  end

  always @(posedge clk) begin
    if (reset) begin
      s_wait_cnt <= 0;
      prev_wait <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      if (!av_read_n && !av_write_n) viol_both <= viol_both + 1;
      if (s_cmd && prev_done) viol_gap <= viol_gap + 1;
      if (s_cmd && prev_wait && s_sig != prev_sig) viol_stable <= viol_stable + 1;
      if (av_writedata[31:8] != 24'h0) viol_hi <= viol_hi + 1;
      prev_sig <= s_sig;
      prev_wait <= s_cmd && av_waitrequest;
      prev_done <= s_cmd && !av_waitrequest;
      if (s_cmd && !av_waitrequest) begin
        stall_log[n_cmd] <= s_wait_cnt;
        n_cmd <= n_cmd + 1;
        s_wait_cnt <= 0;
        if (!av_write_n) begin
          wr_log[n_wr] <= av_writedata[7:0];
          n_wr <= n_wr + 1;
        end else if (!av_address) begin
          n_data_rd <= n_data_rd + 1;
          if (s_rx_tail > s_rx_head) s_rx_head <= s_rx_head + 1;
        end else begin
          n_ctrl_rd <= n_ctrl_rd + 1;
        end
      end else if (s_cmd) begin
        s_wait_cnt <= s_wait_cnt + 1;
      end else begin
        s_wait_cnt <= 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_rx(input logic [7:0] c);
    s_rx_mem[s_rx_tail] = c;
    s_rx_tail++;
  endtask

  task automatic run_until_writes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_wr >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle();
    enable = 1'b0;
    for (int i = 0; i < 200 && state_dbg != 3'd0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] strb;
    strb = {av_read_n, av_write_n, av_address, timeout_err};
    total++; if (strb !== 4'b1100) begin bad++; $display("FAIL reset_strobes: got %b want 1100", strb); end
    total++; if (av_writedata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", av_writedata); end
    total++; if (rx_count !== 16'd0 || tx_count !== 16'd0) begin bad++; $display("FAIL reset_counts: got rx=%0d tx=%0d want 0", rx_count, tx_count); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_echo();
    int w0, d0, c0;
    bit ok;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63;
    mode = 2'd0;
    s_wspace_lim = n_wr + 64;
    push_rx(8'h61); push_rx(8'h62); push_rx(8'h63);
    w0 = n_wr; d0 = n_data_rd; c0 = n_ctrl_rd;
    enable = 1'b1;
    run_until_writes(w0 + 3, 500, ok);
    settle();
    total++; if (!ok) begin bad++; $display("FAIL echo_timeout: got %0d writes want 3", n_wr - w0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (wr_log[w0 + i] !== exp_b[i]) begin bad++; $display("FAIL echo_wr%0d: got %h want %h", i, wr_log[w0 + i], exp_b[i]); end
    end
    total++; if (n_data_rd - d0 != 3) begin bad++; $display("FAIL echo_data_reads: got %0d want 3", n_data_rd - d0); end
    total++; if (n_ctrl_rd - c0 != 1) begin bad++; $display("FAIL echo_ctrl_reads: got %0d want 1", n_ctrl_rd - c0); end
    total++; if (rx_count !== 16'd3 || tx_count !== 16'd3) begin bad++; $display("FAIL echo_counts: got rx=%0d tx=%0d want 3/3", rx_count, tx_count); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL echo_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_upper();
    int w0;
    bit ok;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h5A; exp_b[2] = 8'h7B;
    mode = 2'd1;
    s_wspace_lim = n_wr + 64;
    push_rx(8'h61); push_rx(8'h5A); push_rx(8'h7B);
    w0 = n_wr;
    enable = 1'b1;
    run_until_writes(w0 + 3, 500, ok);
    settle();
    total++; if (!ok) begin bad++; $display("FAIL upper_timeout: got %0d writes want 3", n_wr - w0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (wr_log[w0 + i] !== exp_b[i]) begin bad++; $display("FAIL upper_wr%0d: got %h want %h", i, wr_log[w0 + i], exp_b[i]); end
    end
  endtask

  task automatic test_backpressure();
    int d0, w1, d1, w2;
    bit ok;
    logic [15:0] rx0;
    mode = 2'd0;
    s_wspace_lim = n_wr;
    for (int i = 0; i < 10; i++) push_rx(8'h30 + 8'(i));
    d0 = n_data_rd; rx0 = rx_count;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    settle();
    total++; if (n_data_rd - d0 != 4) begin bad++; $display("FAIL bp_reads_full: got %0d want 4", n_data_rd - d0); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level_full: got %0d want 4", fifo_level); end
    total++; if (rx_count - rx0 != 16'd4) begin bad++; $display("FAIL bp_rx_full: got %0d want 4", rx_count - rx0); end
    // open two slots of write space
    w1 = n_wr; d1 = n_data_rd;
    s_wspace_lim = n_wr + 2;
    enable = 1'b1;
    run_until_writes(w1 + 2, 300, ok);
    repeat (40) @(negedge clk);
    settle();
    total++; if (!ok) begin bad++; $display("FAIL bp_wr_timeout: got %0d writes want 2", n_wr - w1); end
    total++; if (n_wr - w1 != 2) begin bad++; $display("FAIL bp_wr_count: got %0d want 2", n_wr - w1); end
    total++; if (wr_log[w1] !== 8'h30 || wr_log[w1 + 1] !== 8'h31) begin bad++; $display("FAIL bp_wr_bytes: got %h %h want 30 31", wr_log[w1], wr_log[w1 + 1]); end
    total++; if (n_data_rd - d1 != 2) begin bad++; $display("FAIL bp_refill_reads: got %0d want 2", n_data_rd - d1); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level_refill: got %0d want 4", fifo_level); end
    // drain the rest
    w2 = n_wr;
    s_wspace_lim = n_wr + 20;
    enable = 1'b1;
    run_until_writes(w2 + 8, 500, ok);
    settle();
    total++; if (!ok) begin bad++; $display("FAIL bp_drain_timeout: got %0d writes want 8", n_wr - w2); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'h32 + 8'(i);
      total++; if (wr_log[w2 + i] !== e) begin bad++; $display("FAIL bp_drain_wr%0d: got %h want %h", i, wr_log[w2 + i], e); end
    end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL bp_level_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_pattern();
    int w0, d0;
    bit ok;
    mode = 2'd2;
    s_wspace_lim = n_wr + 300;
    w0 = n_wr; d0 = n_data_rd;
    enable = 1'b1;
    run_until_writes(w0 + 300, 2000, ok);
    settle();
    total++; if (!ok) begin bad++; $display("FAIL pat_timeout: got %0d writes want 300", n_wr - w0); end
    for (int i = 0; i < 300; i++) begin
      logic [7:0] e;
      e = 8'(i);
      total++; if (wr_log[w0 + i] !== e) begin bad++; $display("FAIL pat_wr%0d: got %h want %h", i, wr_log[w0 + i], e); end
    end
    total++; if (n_data_rd != d0) begin bad++; $display("FAIL pat_data_reads: got %0d want 0", n_data_rd - d0); end
    total++; if (tx_count !== 16'd316) begin bad++; $display("FAIL pat_tx_count: got %0d want 316", tx_count); end
    total++; if (rx_count !== 16'd16) begin bad++; $display("FAIL pat_rx_count: got %0d want 16", rx_count); end
  endtask

  task automatic test_waitrequest();
    int w0, c0;
    bit ok;
    mode = 2'd0;
    s_wait_n = 5;
    s_wspace_lim = n_wr + 64;
    push_rx(8'h78); push_rx(8'h79);
    w0 = n_wr; c0 = n_cmd;
    enable = 1'b1;
    run_until_writes(w0 + 2, 800, ok);
    settle();
    s_wait_n = 0;
    total++; if (!ok) begin bad++; $display("FAIL wait_timeout: got %0d writes want 2", n_wr - w0); end
    total++; if (n_cmd - c0 != 5) begin bad++; $display("FAIL wait_cmds: got %0d want 5", n_cmd - c0); end
    for (int i = 0; i < 5; i++) begin
      total++; if (stall_log[c0 + i] != 5) begin bad++; $display("FAIL wait_stall%0d: got %0d want 5", i, stall_log[c0 + i]); end
    end
    total++; if (wr_log[w0] !== 8'h78 || wr_log[w0 + 1] !== 8'h79) begin bad++; $display("FAIL wait_bytes: got %h %h want 78 79", wr_log[w0], wr_log[w0 + 1]); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wait_no_terr: got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout();
    int low_cycles, d0;
    bit seen;
    logic [15:0] rx0;
    mode = 2'd0;
    s_hold_all = 1'b1;
    push_rx(8'h71);
    d0 = n_data_rd; rx0 = rx_count;
    low_cycles = 0; seen = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        seen = 1'b1;
        enable = 1'b0;
        break;
      end
      if (!av_read_n) low_cycles++;
    end
    enable = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    total++; if (low_cycles != TO) begin bad++; $display("FAIL to_strobe_cycles: got %0d want %0d", low_cycles, TO); end
    total++; if (av_read_n !== 1'b1) begin bad++; $display("FAIL to_released: got %b want 1", av_read_n); end
    repeat (5) @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    total++; if (fifo_level !== 3'd0 || rx_count !== rx0) begin bad++; $display("FAIL to_fifo: got lvl=%0d rx=%0d want 0/%0d", fifo_level, rx_count, rx0); end
    total++; if (n_data_rd != d0) begin bad++; $display("FAIL to_no_complete: got %0d want 0", n_data_rd - d0); end
    s_hold_all = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    mode = 2'd2;
    s_hold_wr = 1'b1;
    s_wspace_lim = n_wr + 5;
    seen = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (av_write_n === 1'b0) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rst_mid_no_write: got write_n=%b want 0", av_write_n); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    total++; if (av_write_n !== 1'b1 || av_read_n !== 1'b1) begin bad++; $display("FAIL rst_mid_strobes: got rd=%b wr=%b want 1 1", av_read_n, av_write_n); end
    total++; if (rx_count !== 16'd0 || tx_count !== 16'd0) begin bad++; $display("FAIL rst_mid_counts: got rx=%0d tx=%0d want 0", rx_count, tx_count); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_mid_terr: got %b want 0", timeout_err); end
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rst_mid_state: got %0d want 0", state_dbg); end
    @(negedge clk);
    reset = 1'b0;
    s_hold_wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bus_rules();
    total++; if (viol_both != 0) begin bad++; $display("FAIL bus_both_low: got %0d want 0", viol_both); end
    total++; if (viol_gap != 0) begin bad++; $display("FAIL bus_no_gap: got %0d want 0", viol_gap); end
    total++; if (viol_stable != 0) begin bad++; $display("FAIL bus_unstable: got %0d want 0", viol_stable); end
    total++; if (viol_hi != 0) begin bad++; $display("FAIL bus_wdata_hi: got %0d want 0", viol_hi); end
  endtask

  initial begin
    enable = 1'b0;
    mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_echo();
    test_upper();
    test_backpressure();
    test_pattern();
    test_waitrequest();
    test_timeout();
    test_reset_mid_write();
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
